// File: rtl/ethernet_rx.sv
// RMII receive path: preamble/SFD hunt, header parse, destination filter,
// CRC-32 check and a 4-byte delay line that keeps the FCS off the payload stream.
module ethernet_rx #(
   parameter int unsigned MIN_PRE = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   input  logic [47:0] my_mac,
   output logic        axiov,
   output logic [7:0]  axiod,
   output logic [47:0] src_mac,
   output logic [15:0] etype,
   output logic        frame_done,
   output logic        crc_ok,
   output logic        addr_ok
);
   localparam int unsigned PreW = $clog2(MIN_PRE + 2);
   localparam logic [31:0] CrcPoly = 32'hEDB88320;
   localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
   localparam logic [10:0] ByteMax = 11'd2047;

   typedef enum logic [1:0] {StDrop, StHunt, StHeader, StPayload} state_e;

   state_e          state_q, state_d;
   logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
   logic [1:0]      dibit_cnt_q, dibit_cnt_d;
   logic [10:0]     byte_cnt_q, byte_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic [31:0]     crc_q, crc_d;
   logic            mac_match_q, mac_match_d;
   logic            bc_match_q, bc_match_d;
   logic [47:0]     src_sh_q, src_sh_d;
   logic [15:0]     etype_sh_q, etype_sh_d;
   logic [3:0][7:0] dl_q, dl_d;
   logic [2:0]      dl_fill_q, dl_fill_d;
   logic            axiov_q, axiov_d;
   logic [7:0]      axiod_q, axiod_d;
   logic [47:0]     src_mac_q, src_mac_d;
   logic [15:0]     etype_q, etype_d;
   logic            frame_done_q, frame_done_d;
   logic            crc_ok_q, crc_ok_d;
   logic            addr_ok_q, addr_ok_d;

   logic [5:0][7:0] mac_bytes;
   logic [2:0]      mac_idx;
   logic [7:0]      new_byte;
   logic [31:0]     crc_dibit;
   logic            good_addr, good_crc;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
      crc_step = (c >> 1) ^ ((c[0] ^ b) ? CrcPoly : 32'h0);
   endfunction

   assign mac_bytes = my_mac;
   assign mac_idx   = 3'd5 - byte_cnt_q[2:0];
   assign new_byte  = {axiid, shift_q[7:2]};
   assign crc_dibit = crc_step(crc_step(crc_q, axiid[0]), axiid[1]);

   always_comb begin
      state_d      = state_q;
      pre_cnt_d    = pre_cnt_q;
      dibit_cnt_d  = dibit_cnt_q;
      byte_cnt_d   = byte_cnt_q;
      shift_d      = shift_q;
      crc_d        = crc_q;
      mac_match_d  = mac_match_q;
      bc_match_d   = bc_match_q;
      src_sh_d     = src_sh_q;
      etype_sh_d   = etype_sh_q;
      dl_d         = dl_q;
      dl_fill_d    = dl_fill_q;
      axiov_d      = 1'b0;
      axiod_d      = axiod_q;
      src_mac_d    = src_mac_q;
      etype_d      = etype_q;
      frame_done_d = 1'b0;
      crc_ok_d     = 1'b0;
      addr_ok_d    = 1'b0;
      good_addr    = (mac_match_q | bc_match_q) && (byte_cnt_q >= 11'd6);
      good_crc     = (crc_q == CrcResidue) && (byte_cnt_q >= 11'd18) && (dibit_cnt_q == 2'd0);

      unique case (state_q)
         StDrop: begin
            if (!axiiv) begin
               state_d   = StHunt;
               pre_cnt_d = '0;
            end
         end
         StHunt: begin
            if (!axiiv) begin
               pre_cnt_d = '0;
            end else if (axiid == 2'b01) begin
               if (pre_cnt_q < PreW'(MIN_PRE)) pre_cnt_d = pre_cnt_q + PreW'(1);
            end else if (axiid == 2'b11 && pre_cnt_q >= PreW'(MIN_PRE)) begin
               state_d     = StHeader;
               crc_d       = '1;
               dibit_cnt_d = '0;
               byte_cnt_d  = '0;
               mac_match_d = 1'b1;
               bc_match_d  = 1'b1;
               dl_fill_d   = '0;
            end else begin
               state_d = StDrop;
            end
         end
         StHeader, StPayload: begin
            if (!axiiv) begin
               frame_done_d = 1'b1;
               crc_ok_d     = good_crc;
               addr_ok_d    = good_addr;
               if (good_crc && good_addr) begin
                  src_mac_d = src_sh_q;
                  etype_d   = etype_sh_q;
               end
               dl_d      = '0;
               dl_fill_d = '0;
               pre_cnt_d = '0;
               state_d   = StHunt;
            end else begin
               crc_d       = crc_dibit;
               shift_d     = new_byte;
               dibit_cnt_d = dibit_cnt_q + 2'd1;
               if (dibit_cnt_q == 2'd3) begin
                  if (byte_cnt_q != ByteMax) byte_cnt_d = byte_cnt_q + 11'd1;
                  if (state_q == StHeader) begin
                     if (byte_cnt_q < 11'd6) begin
                        if (new_byte != mac_bytes[mac_idx]) mac_match_d = 1'b0;
                        if (new_byte != 8'hFF) bc_match_d = 1'b0;
                     end else if (byte_cnt_q < 11'd12) begin
                        src_sh_d = {src_sh_q[39:0], new_byte};
                     end else begin
                        etype_sh_d = {etype_sh_q[7:0], new_byte};
                     end
                     if (byte_cnt_q == 11'd13) state_d = StPayload;
                  end else begin
                     // Oldest byte leaves only once four newer bytes exist, so FCS never escapes
                     dl_d = {dl_q[2:0], new_byte};
                     if (dl_fill_q == 3'd4) begin
                        if (mac_match_q | bc_match_q) begin
                           axiov_d = 1'b1;
                           axiod_d = dl_q[3];
                        end
                     end else begin
                        dl_fill_d = dl_fill_q + 3'd1;
                     end
                  end
               end
            end
         end
         default: state_d = StDrop;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StDrop;
         pre_cnt_q    <= '0;
         dibit_cnt_q  <= '0;
         byte_cnt_q   <= '0;
         shift_q      <= '0;
         crc_q        <= '1;
         mac_match_q  <= 1'b0;
         bc_match_q   <= 1'b0;
         src_sh_q     <= '0;
         etype_sh_q   <= '0;
         dl_q         <= '0;
         dl_fill_q    <= '0;
         axiov_q      <= 1'b0;
         axiod_q      <= '0;
         src_mac_q    <= '0;
         etype_q      <= '0;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         addr_ok_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pre_cnt_q    <= pre_cnt_d;
         dibit_cnt_q  <= dibit_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         shift_q      <= shift_d;
         crc_q        <= crc_d;
         mac_match_q  <= mac_match_d;
         bc_match_q   <= bc_match_d;
         src_sh_q     <= src_sh_d;
         etype_sh_q   <= etype_sh_d;
         dl_q         <= dl_d;
         dl_fill_q    <= dl_fill_d;
         axiov_q      <= axiov_d;
         axiod_q      <= axiod_d;
         src_mac_q    <= src_mac_d;
         etype_q      <= etype_d;
         frame_done_q <= frame_done_d;
         crc_ok_q     <= crc_ok_d;
         addr_ok_q    <= addr_ok_d;
      end
   end

   assign axiov      = axiov_q;
   assign axiod      = axiod_q;
   assign src_mac    = src_mac_q;
   assign etype      = etype_q;
   assign frame_done = frame_done_q;
   assign crc_ok     = crc_ok_q;
   assign addr_ok    = addr_ok_q;

endmodule

// File: tb/tb_ethernet_rx.sv
// Randomized scoreboard bench for ethernet_rx: frames are built from fields, expectations
// are derived from frame-level rules and checked by an independent monitor.
module tb_ethernet_rx;
   localparam int MIN_PRE = 8;
   localparam logic [47:0] MY_MAC = 48'h0A1B2C3D4E5F;
   localparam logic [47:0] SRC    = 48'h112233445566;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        axiiv = 1'b0;
   logic [1:0]  axiid = 2'b00;
   logic [47:0] my_mac = MY_MAC;
   logic        axiov;
   logic [7:0]  axiod;
   logic [47:0] src_mac;
   logic [15:0] etype;
   logic        frame_done, crc_ok, addr_ok;

   ethernet_rx #(.MIN_PRE(MIN_PRE)) dut (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .my_mac(my_mac),
      .axiov(axiov), .axiod(axiod), .src_mac(src_mac), .etype(etype),
      .frame_done(frame_done), .crc_ok(crc_ok), .addr_ok(addr_ok)
   );

   always #10 clk = ~clk;

   typedef struct packed {
      logic        crc;
      logic        addr;
      logic [47:0] src;
      logic [15:0] et;
   } done_t;

   logic [7:0]  exp_bytes[$];
   done_t       exp_done[$];
   logic [7:0]  fb[$];
   logic [47:0] m_src = '0;
   logic [15:0] m_et = '0;
   int          checks = 0;
   int          passed = 0;
   int          strobe_err = 0;
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic fail_event(input string name, input logic [63:0] act);
      checks++;
      $display("FAIL %s: got %h, expected no such event", name, act);
   endtask

   function automatic logic [31:0] crc32(input int len);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < len; i++)
         for (int j = 0; j < 8; j++)
            c = (c[0] ^ fb[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   task automatic build_frame(input logic [47:0] dest, input logic [15:0] et, input int plen,
                              input bit rnd);
      logic [31:0] fcs;
      fb.delete();
      for (int i = 5; i >= 0; i--) fb.push_back(dest[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fb.push_back(SRC[8*i +: 8]);
      fb.push_back(et[15:8]);
      fb.push_back(et[7:0]);
      for (int i = 0; i < plen; i++) fb.push_back(rnd ? 8'($urandom) : 8'(i));
      fcs = ~crc32(fb.size());
      for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
   endtask

   // Frame-level rules: payload is bytes 14..n-5 when addressed to us; FCS must match
   task automatic expect_frame(input int pre, input int k);
      int          n;
      logic [47:0] dest;
      logic [31:0] fcs;
      logic        a, g;
      n = fb.size();
      if (pre < MIN_PRE) return;
      dest = '0;
      if (n >= 6) for (int i = 0; i < 6; i++) dest = {dest[39:0], fb[i]};
      a = (n >= 6) && (dest == MY_MAC || dest == 48'hFFFF_FFFF_FFFF);
      g = 1'b0;
      if (n >= 18 && k == 0) begin
         fcs = ~crc32(n - 4);
         g = ({fb[n-1], fb[n-2], fb[n-3], fb[n-4]} == fcs);
      end
      if (a) for (int i = 14; i <= n - 5; i++) exp_bytes.push_back(fb[i]);
      if (a && g) begin
         m_src = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
         m_et  = {fb[12], fb[13]};
      end
      exp_done.push_back('{crc: g, addr: a, src: m_src, et: m_et});
   endtask

   task automatic drive(input logic v, input logic [1:0] d);
      @(negedge clk);
      axiiv = v;
      axiid = d;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 4; i++) drive(1'b1, b[2*i +: 2]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom));
   endtask

   task automatic send_frame(input int pre, input int k);
      for (int i = 0; i < pre; i++) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      foreach (fb[i]) send_byte(fb[i]);
      for (int i = 0; i < k; i++) drive(1'b1, 2'($urandom));
      idle(3);
   endtask

   task automatic run_frame(input int pre, input int k);
      expect_frame(pre, k);
      send_frame(pre, k);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_axiov"}, axiov, 0);
      check({tag, "_axiod"}, axiod, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_crc_ok"}, crc_ok, 0);
      check({tag, "_addr_ok"}, addr_ok, 0);
      check({tag, "_src_mac"}, src_mac, 0);
      check({tag, "_etype"}, etype, 0);
   endtask

   // Monitor: pops expectations whenever the DUT presents an output strobe
   initial begin
      logic [7:0] eb;
      done_t      ed;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (axiov) begin
               if (exp_bytes.size() == 0) fail_event("unexpected_axiov", axiod);
               else begin
                  eb = exp_bytes.pop_front();
                  check("payload_byte", axiod, eb);
               end
            end
            if (frame_done) begin
               if (exp_done.size() == 0) fail_event("unexpected_frame_done", {crc_ok, addr_ok});
               else begin
                  ed = exp_done.pop_front();
                  check("crc_ok", crc_ok, ed.crc);
                  check("addr_ok", addr_ok, ed.addr);
                  check("src_mac", src_mac, ed.src);
                  check("etype", etype, ed.et);
               end
            end else if (crc_ok || addr_ok) begin
               strobe_err++;
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, checks);
      $fatal(1, "timeout");
   end

   initial begin
      int pre, k, sel, f, nn, idx;
      logic [47:0] dest;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      mon_en = 1'b1;
      idle(4);

      // Directed reference frame, then the same with payload byte 10 bit 0 flipped
      build_frame(MY_MAC, 16'h0800, 46, 1'b0);
      run_frame(31, 0);
      build_frame(MY_MAC, 16'h0800, 46, 1'b0);
      fb[24] = fb[24] ^ 8'h01;
      run_frame(31, 0);

      build_frame(48'hFFFF_FFFF_FFFF, 16'h86DD, 46, 1'b1);
      run_frame(20, 0);
      build_frame(48'h020000000001, 16'h0806, 46, 1'b1);
      run_frame(20, 0);

      // Short preamble rejected, runt in header, preamble boundary, minimum frame
      build_frame(MY_MAC, 16'h0800, 46, 1'b0);
      run_frame(4, 0);
      build_frame(MY_MAC, 16'h0800, 46, 1'b0);
      while (fb.size() > 10) void'(fb.pop_back());
      run_frame(31, 0);
      build_frame(MY_MAC, 16'h1234, 20, 1'b1);
      run_frame(MIN_PRE - 1, 0);
      build_frame(MY_MAC, 16'h1234, 20, 1'b1);
      run_frame(MIN_PRE, 0);
      build_frame(MY_MAC, 16'h4321, 0, 1'b0);
      run_frame(12, 0);
      build_frame(MY_MAC, 16'h4321, 1, 1'b0);
      void'(fb.pop_back());
      run_frame(12, 0);
      build_frame(MY_MAC, 16'h5555, 30, 1'b1);
      run_frame(12, 2);

      // Reset during payload byte 20 (frame byte 34) with axiiv held high
      build_frame(MY_MAC, 16'h0800, 46, 1'b1);
      for (int i = 14; i <= 34 - 5; i++) exp_bytes.push_back(fb[i]);
      for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
      drive(1'b1, 2'b11);
      for (int i = 0; i < 34; i++) send_byte(fb[i]);
      @(negedge clk);
      rst = 1'b1;
      axiiv = 1'b1;
      axiid = fb[34][1:0];
      @(negedge clk);
      rst = 1'b0;
      m_src = '0;
      m_et = '0;
      check_all_zero("mid_frame_reset");
      axiid = fb[34][3:2];
      for (int i = 35; i < fb.size(); i++) send_byte(fb[i]);
      idle(3);
      build_frame(MY_MAC, 16'h0800, 46, 1'b0);
      run_frame(31, 0);

      // Randomized frames
      for (int t = 0; t < 24; t++) begin
         pre = ($urandom_range(0, 7) == 0) ? $urandom_range(1, MIN_PRE - 1)
                                           : $urandom_range(MIN_PRE, 31);
         sel = $urandom_range(0, 3);
         dest = (sel == 1) ? 48'hFFFF_FFFF_FFFF
              : (sel == 2) ? {8'h02, 32'($urandom), 8'h00} : MY_MAC;
         build_frame(dest, 16'($urandom), $urandom_range(0, 60), 1'b1);
         k = 0;
         f = $urandom_range(0, 4);
         if (f == 1) begin
            idx = $urandom_range(0, fb.size() - 1);
            fb[idx] = fb[idx] ^ 8'(1 << $urandom_range(0, 7));
         end else if (f == 2) begin
            nn = $urandom_range(1, fb.size() - 1);
            while (fb.size() > nn) void'(fb.pop_back());
         end else if (f == 3) begin
            k = $urandom_range(1, 3);
         end
         run_frame(pre, k);
         idle($urandom_range(0, 5));
      end

      idle(10);
      check("leftover_bytes", exp_bytes.size(), 0);
      check("leftover_frames", exp_done.size(), 0);
      check("strobes_outside_frame_done", strobe_err, 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/ethernet_rx.md
ETHERNET_RX -- requirements
Module: ethernet_rx

Interface
REQ-001 Parameter MIN_PRE, default 8: minimum number of 2'b01 dibits required before the SFD-terminating 2'b11 dibit.
REQ-002 clk  input  1  single clock for all logic, 50 MHz RMII reference.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 axiiv  input  1  receive data valid (RMII CRS_DV); high for the whole frame including preamble.
REQ-005 axiid  input  2  receive dibit in wire order: each byte arrives least-significant dibit first.
REQ-006 my_mac  input  48  MAC address of this FPGA, for destination filtering.
REQ-007 axiov  output  1  payload byte valid, one-cycle strobe.
REQ-008 axiod  output  8  payload byte, valid when axiov=1.
REQ-009 src_mac  output  48  source MAC of the last accepted frame.
REQ-010 etype  output  16  EtherType of the last accepted frame, first byte received in [15:8].
REQ-011 frame_done  output  1  one-cycle strobe marking end of any frame that reached HEADER.
REQ-012 crc_ok  output  1  FCS check result, valid while frame_done=1.
REQ-013 addr_ok  output  1  destination match result, valid while frame_done=1.

Function
REQ-014 The FSM shall have states DROP, HUNT, HEADER, PAYLOAD; reset state is DROP.
REQ-015 DROP: ignore axiid; go to HUNT on the first cycle axiiv=0.
REQ-016 HUNT: count consecutive 2'b01 dibits while axiiv=1; 2'b11 with count>=MIN_PRE -> HEADER; any other dibit or 2'b11 too early -> DROP; axiiv=0 -> clear count, stay in HUNT.
REQ-017 HEADER/PAYLOAD: assemble bytes LSB-dibit-first; a byte completes on every 4th valid dibit.
REQ-018 Header bytes 0-5 are compared with my_mac (byte 0 = my_mac[47:40]); addr_ok=1 if all equal or all 0xFF.
REQ-019 Header bytes 6-11 shall load src_mac (byte 6 -> [47:40]); bytes 12-13 load etype; both update only when frame_done fires with crc_ok=1 and addr_ok=1, otherwise they hold their previous values.
REQ-020 After byte 13, go to PAYLOAD.
REQ-021 CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per dibit, LSB first, over all bits from destination byte 0 through the last FCS bit.
REQ-022 crc_ok=1 iff the final CRC register equals residue 0xDEBB20E3, the byte count is >=18, and the dibit count is a multiple of 4.
REQ-023 PAYLOAD bytes shall pass through a 4-byte delay line, so the 4 FCS bytes are never emitted.
REQ-024 A completed byte pushed into a full delay line shall emit the oldest byte, with axiov=1 on the cycle after the byte's 4th dibit.
REQ-025 Payload is emitted only when the destination matches; a non-matching frame produces no axiov pulses.
REQ-026 Emitted bytes are not retracted on CRC failure; consumers shall gate on crc_ok at frame_done.
REQ-027 End of frame is axiiv=0 in HEADER or PAYLOAD. On the next cycle: frame_done=1, crc_ok/addr_ok valid, delay line cleared, state -> HUNT.
REQ-028 Runt frames, with end in HEADER or fewer than 18 bytes, shall produce frame_done=1 with crc_ok=0 and no further axiov.
REQ-029 A partial trailing byte (1-3 dibits) shall be discarded and force crc_ok=0.
REQ-030 The byte counter shall saturate at 2047, with no wrap-around.
REQ-031 frame_done, crc_ok and addr_ok shall be 0 on every cycle except the frame_done cycle.

Reset
REQ-032 On rst=1 at any clock edge, including mid-frame, the following shall clear: state=DROP; axiov=0, axiod=0, frame_done=0, crc_ok=0, addr_ok=0, src_mac=0, etype=0; all counters and the delay line.
REQ-033 After rst releases mid-frame, the remainder of that frame shall be ignored, because DROP waits for axiiv=0.

Verification
REQ-034 Stimulus: 31x01 + 11 preamble/SFD, dest=my_mac=0x0A1B2C3D4E5F, src 0x112233445566, etype 0x0800, payload 46 bytes 0x00..0x2D, correct FCS. Response: 46 axiov pulses 0x00..0x2D in order; then frame_done=1, crc_ok=1, addr_ok=1, src_mac=0x112233445566, etype=0x0800.
REQ-035 Stimulus: same frame with payload byte 10 bit 0 flipped. Response: 46 axiov pulses; frame_done=1, crc_ok=0; src_mac/etype unchanged from the previous frame.
REQ-036 Stimulus: dest=0xFFFFFFFFFFFF, then dest=0x020000000001 (not my_mac). Response: first frame addr_ok=1 with payload emitted; second frame addr_ok=0 with zero axiov pulses.
REQ-037 Stimulus: preamble of only 4x01 then 11. Response: return to DROP, no frame_done. Separately, axiiv drops after 10 header bytes: frame_done=1, crc_ok=0.
REQ-038 Stimulus: rst pulsed during payload byte 20 while axiiv stays high. Response: all outputs 0 from the next cycle, no further axiov; the next clean frame is received with crc_ok=1.
